// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one sync FIFO write port among NUM_REQ packet sources.
// A grant is held for a whole packet or BURST_MAX beats, then rotates to the next source.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_MAX  = 8
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic [DATA_WIDTH-1:0]         fifo_din_o,
    output logic                          fifo_wr_en_o,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
    output logic                          busy_o
);
    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(BURST_MAX + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  grant_id_q;
    logic [CW-1:0]   beat_cnt_q;

    logic [IDW-1:0]        pick_c;
    logic                  any_valid_c;
    logic                  owner_valid_c;
    logic                  owner_last_c;
    logic [DATA_WIDTH-1:0] owner_data_c;
    logic                  accept_c;
    logic                  release_c;
    logic [CW-1:0]         beat_cnt_inc_c;
    logic [IDW-1:0]        next_ptr_c;

    // First valid source searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ
    always_comb begin
        int unsigned idx;
        idx         = 0;
        pick_c      = rr_ptr_q;
        any_valid_c = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_valid_c && req_valid_i[IDW'(idx)]) begin
                pick_c      = IDW'(idx);
                any_valid_c = 1'b1;
            end
        end
    end

    assign owner_valid_c  = req_valid_i[grant_id_q];
    assign owner_last_c   = req_last_i[grant_id_q];
    assign owner_data_c   = req_data_i[32'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
    assign accept_c       = (state_q == ST_GRANT) && owner_valid_c && !fifo_full_i;
    assign beat_cnt_inc_c = beat_cnt_q + CW'(1);
    assign release_c      = accept_c && (owner_last_c || (beat_cnt_inc_c == CW'(BURST_MAX)));
    assign next_ptr_c     = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    // Write-port steering follows the owner within the current cycle
    always_comb begin
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        fifo_din_o   = '0;
        if (state_q == ST_GRANT) begin
            req_ready_o[grant_id_q] = !fifo_full_i;
            fifo_wr_en_o            = accept_c;
            if (accept_c) begin
                fifo_din_o = owner_data_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_valid_c) begin
                        grant_id_q <= pick_c;
                        beat_cnt_q <= '0;
                        state_q    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (release_c) begin
                        rr_ptr_q   <= next_ptr_c;
                        beat_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else if (accept_c) begin
                        beat_cnt_q <= beat_cnt_inc_c;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant_id_o = grant_id_q;
    assign busy_o     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: source models feed packets, a monitor checks each FIFO write.
// Instance a uses BURST_MAX=8, instance b uses BURST_MAX=4 for forced-rotation vectors.
module tb_fifo_wr_arbiter;
    localparam int unsigned NR    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned IW    = 2;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             srstn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_last;
    logic [NR*DW-1:0] req_data;
    logic             fifo_full;
    logic [NR-1:0]    ready_a, ready_b;
    logic [DW-1:0]    din_a, din_b;
    logic             wr_a, wr_b, busy_a, busy_b;
    logic [IW-1:0]    gid_a, gid_b;

    beat_t         src_mem [NR][DEPTH];
    int            src_rd  [NR];
    int            src_wr  [NR];
    logic [NR-1:0] pause;
    logic [NR-1:0] fire;
    bit            sel_b, chk_a, chk_b;
    wr_t           exp_a [$];
    wr_t           exp_b [$];
    int            total  = 0;
    int            passed = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(8)) u_dut_a (
        .clk(clk), .srstn(srstn),
        .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
        .req_ready_o(ready_a), .fifo_full_i(fifo_full),
        .fifo_din_o(din_a), .fifo_wr_en_o(wr_a), .grant_id_o(gid_a), .busy_o(busy_a)
    );

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(4)) u_dut_b (
        .clk(clk), .srstn(srstn),
        .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
        .req_ready_o(ready_b), .fifo_full_i(fifo_full),
        .fifo_din_o(din_b), .fifo_wr_en_o(wr_b), .grant_id_o(gid_b), .busy_o(busy_b)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NR; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_valid[i]          = !pause[i];
                req_last[i]           = src_mem[i][src_rd[i]].last;
                req_data[i*DW +: DW]  = src_mem[i][src_rd[i]].data;
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NR; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        pause = '0;
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < NR; i++) begin
            if (src_rd[i] < src_wr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic add_beat(int s, logic [DW-1:0] d, logic l);
        src_mem[s][src_wr[s]] = '{data: d, last: l};
        src_wr[s]++;
    endtask

    task automatic expect_wr(bit on_b, int id, logic [DW-1:0] d);
        wr_t e;
        e = '{id: IW'(id), data: d};
        if (on_b) exp_b.push_back(e);
        else exp_a.push_back(e);
    endtask

    // Source model: a beat leaves its queue after a cycle with valid & ready
    always begin
        @(negedge clk);
        fire = (sel_b ? ready_b : ready_a) & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (fire[i] === 1'b1 && src_rd[i] < src_wr[i]) src_rd[i]++;
        end
        apply_inputs();
    end

    // Monitor: full-protection on every full cycle, scoreboard pop on every write
    always @(negedge clk) begin
        wr_t e;
        if (fifo_full === 1'b1) check("no_write_when_full", 32'({wr_a, wr_b}), 32'd0);
        if (chk_a && wr_a === 1'b1) begin
            if (exp_a.size() == 0) begin
                total++;
                $display("FAIL unexpected_write_a: din=0x%0h grant=%0d, required no write", din_a, gid_a);
            end else begin
                e = exp_a.pop_front();
                check("din_a", 32'(din_a), 32'(e.data));
                check("grant_a", 32'(gid_a), 32'(e.id));
            end
        end
        if (chk_b && wr_b === 1'b1) begin
            if (exp_b.size() == 0) begin
                total++;
                $display("FAIL unexpected_write_b: din=0x%0h grant=%0d, required no write", din_b, gid_b);
            end else begin
                e = exp_b.pop_front();
                check("din_b", 32'(din_b), 32'(e.data));
                check("grant_b", 32'(gid_b), 32'(e.id));
            end
        end
    end

    task automatic check_cycles(string name, int n, logic [15:0] pat);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check(name, 32'(sel_b ? wr_b : wr_a), 32'(pat[j]));
        end
    endtask

    task automatic do_reset();
        #1;
        srstn     = 1'b0;
        fifo_full = 1'b0;
        clear_sources();
        apply_inputs();
        @(posedge clk);
        #2;
        srstn = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'({busy_a, busy_b}), 32'd0);
        check("rst_wr_en", 32'({wr_a, wr_b}), 32'd0);
        check("rst_grant", 32'({gid_a, gid_b}), 32'd0);
        check("rst_ready", 32'({ready_a, ready_b}), 32'd0);
        check("rst_din", 32'({din_a, din_b}), 32'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(string name, int budget);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0 || !sources_empty()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n < budget) passed++;
        else $display("FAIL %s: %0d writes still pending after %0d cycles, required 0",
                      name, exp_a.size() + exp_b.size(), budget);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        srstn = 1'b0; fifo_full = 1'b0; sel_b = 1'b0; chk_a = 1'b1; chk_b = 1'b0;
        clear_sources();
        apply_inputs();
        @(posedge clk);
        #2;

        // Single 3-beat packet: one bubble then three back-to-back writes
        do_reset();
        add_beat(0, 8'h11, 1'b0); add_beat(0, 8'h22, 1'b0); add_beat(0, 8'h33, 1'b1);
        expect_wr(0, 0, 8'h11); expect_wr(0, 0, 8'h22); expect_wr(0, 0, 8'h33);
        apply_inputs();
        check_cycles("t1_wr_pattern", 5, 16'h000E);
        wait_drain("t1_drain", 50);

        // Four sources with 1-beat packets rotate 0,1,2,3,0,1
        do_reset();
        add_beat(0, 8'h01, 1'b1); add_beat(0, 8'h05, 1'b1);
        add_beat(1, 8'h02, 1'b1); add_beat(1, 8'h06, 1'b1);
        add_beat(2, 8'h03, 1'b1); add_beat(3, 8'h04, 1'b1);
        expect_wr(0, 0, 8'h01); expect_wr(0, 1, 8'h02); expect_wr(0, 2, 8'h03);
        expect_wr(0, 3, 8'h04); expect_wr(0, 0, 8'h05); expect_wr(0, 1, 8'h06);
        apply_inputs();
        check_cycles("t2_wr_pattern", 13, 16'h0AAA);
        wait_drain("t2_drain", 50);

        // FIFO full for 3 cycles after beat 2 of a 5-beat packet
        do_reset();
        for (int k = 0; k < 5; k++) begin
            add_beat(2, 8'h51 + 8'(k), (k == 4));
            expect_wr(0, 2, 8'h51 + 8'(k));
        end
        apply_inputs();
        check_cycles("t3_pre_full", 3, 16'h0006);
        @(posedge clk);
        #2;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_ready_when_full", 32'(ready_a), 32'd0);
            check("t3_grant_held", 32'(gid_a), 32'd2);
            check("t3_busy_held", 32'(busy_a), 32'd1);
        end
        @(posedge clk);
        #2;
        fifo_full = 1'b0;
        check_cycles("t3_post_full", 4, 16'h0007);
        wait_drain("t3_drain", 50);

        // BURST_MAX=4: src1 streams 10 beats, src2 gets a turn between fragments
        sel_b = 1'b1; chk_a = 1'b0; chk_b = 1'b1;
        do_reset();
        for (int k = 0; k < 10; k++) add_beat(1, 8'h61 + 8'(k), (k == 9));
        add_beat(2, 8'h71, 1'b0); add_beat(2, 8'h72, 1'b1);
        for (int k = 0; k < 4; k++) expect_wr(1, 1, 8'h61 + 8'(k));
        expect_wr(1, 2, 8'h71); expect_wr(1, 2, 8'h72);
        for (int k = 4; k < 10; k++) expect_wr(1, 1, 8'h61 + 8'(k));
        apply_inputs();
        check_cycles("t4_wr_pattern", 16, 16'hDEDE);
        wait_drain("t4_drain", 60);
        sel_b = 1'b0; chk_a = 1'b1; chk_b = 1'b0;

        // Reset during beat 2 of src2, then arbitration restarts from index 0
        do_reset();
        add_beat(0, 8'h80, 1'b1);
        for (int k = 0; k < 4; k++) add_beat(2, 8'h81 + 8'(k), (k == 3));
        expect_wr(0, 0, 8'h80); expect_wr(0, 2, 8'h81); expect_wr(0, 2, 8'h82);
        apply_inputs();
        check_cycles("t5_pre_reset", 5, 16'h001A);
        do_reset();
        add_beat(0, 8'h90, 1'b1); add_beat(3, 8'h93, 1'b1);
        expect_wr(0, 0, 8'h90); expect_wr(0, 3, 8'h93);
        apply_inputs();
        wait_drain("t5_drain", 50);

        // Owner src3 pauses 4 cycles mid-packet while src0 waits
        do_reset();
        for (int k = 0; k < 4; k++) begin
            add_beat(3, 8'hA1 + 8'(k), (k == 3));
            expect_wr(0, 3, 8'hA1 + 8'(k));
        end
        expect_wr(0, 0, 8'hB1);
        apply_inputs();
        check_cycles("t6_pre_pause", 3, 16'h0006);
        @(posedge clk);
        #2;
        pause[3] = 1'b1;
        add_beat(0, 8'hB1, 1'b1);
        apply_inputs();
        repeat (4) begin
            @(negedge clk);
            check("t6_no_write_paused", 32'(wr_a), 32'd0);
            check("t6_grant_held", 32'(gid_a), 32'd3);
            check("t6_busy_held", 32'(busy_a), 32'd1);
        end
        @(posedge clk);
        #2;
        pause[3] = 1'b0;
        apply_inputs();
        check_cycles("t6_post_pause", 5, 16'h000B);
        wait_drain("t6_drain", 50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
